// File: rtl/fp_tc_pkg.sv
// Shared definitions for the compact-float to two's-complement decoder.
// State encodings, default widths and the largest representable magnitude.
package fp_tc_pkg;

  localparam int DEF_EXP_W = 3;
  localparam int DEF_SIG_W = 4;
  localparam int DEF_OUT_W = 12;

  // Largest magnitude: (2^SIG_W - 1) * 2^(2^EXP_W - 1)
  localparam int TC_MAX_MAG = 1920;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sm_to_tc.sv
// Sign-magnitude to two's-complement conversion.
// A zero magnitude maps to zero regardless of sign.
module sm_to_tc #(
  parameter int OUT_W = 12
) (
  input  logic             sign,
  input  logic [OUT_W-2:0] mag,
  output logic [OUT_W-1:0] tc
);

  logic [OUT_W-1:0] ext;

  // Negate the zero-extended magnitude when the sign is set
  always_comb begin
    ext = {1'b0, mag};
    tc  = sign ? (~ext + OUT_W'(1)) : ext;
  end

endmodule

// File: rtl/fp_to_tc_seq.sv
// Sequential decoder: compact float {S,E,F} to OUT_W-bit two's complement.
// Define TC_FAST_SHIFT_EN for a one-cycle barrel shift instead of shift-per-cycle.
module fp_to_tc_seq
  import fp_tc_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [SIG_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D
);

  localparam int MW = OUT_W - 1;

  state_e           state_q, state_d;
  logic [MW-1:0]    mag_q, mag_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic [MW-1:0]    f_ext;
  logic             tc_sign;
  logic [MW-1:0]    tc_mag;
  logic [OUT_W-1:0] tc_val;

  // Input capture and the operand feeding the DONE-entry conversion
  always_comb begin
    accept = in_valid && in_ready;
    f_ext  = {{(MW-SIG_W){1'b0}}, F};
`ifdef TC_FAST_SHIFT_EN
    tc_sign = S;
    tc_mag  = f_ext << E;
`else
    tc_sign = sign_q;
    tc_mag  = mag_q;
`endif
  end

  sm_to_tc #(
    .OUT_W (OUT_W)
  ) u_sm_to_tc (
    .sign (tc_sign),
    .mag  (tc_mag),
    .tc   (tc_val)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef TC_FAST_SHIFT_EN
          state_d = DONE;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (ov_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture, shift, convert, release
  always_comb begin
    mag_d  = mag_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    d_d    = d_q;
    ov_d   = ov_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mag_d  = f_ext;
          cnt_d  = E;
          sign_d = S;
`ifdef TC_FAST_SHIFT_EN
          d_d    = tc_val;
          ov_d   = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - EXP_W'(1);
        end else begin
          d_d  = tc_val;
          ov_d = 1'b1;
        end
      end
      DONE: begin
        if (ov_q && out_ready) ov_d = 1'b0;
      end
      default: ov_d = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      d_q    <= '0;
      ov_q   <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      d_q    <= d_d;
      ov_q   <= ov_d;
    end
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = ov_q;
    D         = d_q;
  end

endmodule
